// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: filters SCL/SDA, detects START/STOP and reports each
// 9-bit frame as a byte plus ACK. Never drives the bus.
module i2c_bus_monitor #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned TOUT     = 768
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       isck,
  input  logic       isda,
  output logic       obusy,
  output logic       ostart,
  output logic       ostop,
  output logic       oerr,
  output logic       obyte_val,
  output logic [7:0] obyte,
  output logic       oack,
  output logic       ofirst,
  output logic [7:0] ocnt
);

  localparam int unsigned RUN_W  = 4;
  localparam int unsigned TOUT_W = 16;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [RUN_W-1:0]  FILT_LAST = RUN_W'(FILT_LEN - 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT - 1);
  localparam logic [BIT_W-1:0]  ACK_BIT   = BIT_W'(8);
  localparam logic [BYTE_W-1:0] CNT_MAX   = BYTE_W'(255);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       filt;
  logic [1:0]       filt_q;
  logic [1:0]       filt_qq;
  logic [RUN_W-1:0] run_cnt [2];

  state_t              state, nxt_state;
  logic [BIT_W-1:0]    bit_cnt, nxt_bit_cnt;
  logic [BYTE_W-1:0]   shreg, nxt_shreg;
  logic [TOUT_W-1:0]   tcnt, nxt_tcnt;
  logic [BYTE_W-1:0]   byte_cnt, nxt_byte_cnt;

  // Frame capture stage, presented on the outputs one cycle later.
  logic              val_s, nxt_val_s;
  logic [BYTE_W-1:0] byte_s, nxt_byte_s;
  logic              ack_s, nxt_ack_s;
  logic              first_s, nxt_first_s;
  logic [BYTE_W-1:0] cnt_s, nxt_cnt_s;

  logic              nxt_busy, nxt_start, nxt_stop, nxt_err, nxt_byte_val;
  logic [BYTE_W-1:0] nxt_obyte, nxt_ocnt;
  logic              nxt_oack, nxt_ofirst;

  logic scl_l, sda_l;
  logic scl_rise_c, scl_edge_c, sda_rise_c, sda_fall_c;
  logic start_c, stop_c;

  // Two-flop synchronisers, glitch filters and one extra stage for edge detection.
  always_ff @(posedge iclk) begin
    if (irst) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      filt_q     <= 2'b11;
      filt_qq    <= 2'b11;
      run_cnt[0] <= '0;
      run_cnt[1] <= '0;
    end else begin
      sync1   <= {isda, isck};
      sync2   <= sync1;
      filt_q  <= filt;
      filt_qq <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          run_cnt[i] <= '0;
        end else if (run_cnt[i] == FILT_LAST) begin
          filt[i]    <= sync2[i];
          run_cnt[i] <= '0;
        end else begin
          run_cnt[i] <= run_cnt[i] + RUN_W'(1);
        end
      end
    end
  end

  // Edge flags on the registered filtered lines; SCL activity masks SDA conditions.
  always_comb begin
    scl_l      = filt_q[0];
    sda_l      = filt_q[1];
    scl_rise_c = filt_q[0] & ~filt_qq[0];
    scl_edge_c = filt_q[0] ^ filt_qq[0];
    sda_rise_c = filt_q[1] & ~filt_qq[1];
    sda_fall_c = ~filt_q[1] & filt_qq[1];
    start_c    = sda_fall_c & scl_l & ~scl_edge_c;
    stop_c     = sda_rise_c & scl_l & ~scl_edge_c;
  end

  // State and output registers.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tcnt      <= '0;
      byte_cnt  <= '0;
      val_s     <= 1'b0;
      byte_s    <= '0;
      ack_s     <= 1'b0;
      first_s   <= 1'b0;
      cnt_s     <= '0;
      obusy     <= 1'b0;
      ostart    <= 1'b0;
      ostop     <= 1'b0;
      oerr      <= 1'b0;
      obyte_val <= 1'b0;
      obyte     <= '0;
      oack      <= 1'b0;
      ofirst    <= 1'b0;
      ocnt      <= '0;
    end else begin
      state     <= nxt_state;
      bit_cnt   <= nxt_bit_cnt;
      shreg     <= nxt_shreg;
      tcnt      <= nxt_tcnt;
      byte_cnt  <= nxt_byte_cnt;
      val_s     <= nxt_val_s;
      byte_s    <= nxt_byte_s;
      ack_s     <= nxt_ack_s;
      first_s   <= nxt_first_s;
      cnt_s     <= nxt_cnt_s;
      obusy     <= nxt_busy;
      ostart    <= nxt_start;
      ostop     <= nxt_stop;
      oerr      <= nxt_err;
      obyte_val <= nxt_byte_val;
      obyte     <= nxt_obyte;
      oack      <= nxt_oack;
      ofirst    <= nxt_ofirst;
      ocnt      <= nxt_ocnt;
    end
  end

  // Next-state: START/STOP, frame deserialisation and SCL-stall timeout.
  always_comb begin
    nxt_state    = state;
    nxt_bit_cnt  = bit_cnt;
    nxt_shreg    = shreg;
    nxt_tcnt     = tcnt;
    nxt_byte_cnt = byte_cnt;
    nxt_val_s    = 1'b0;
    nxt_byte_s   = byte_s;
    nxt_ack_s    = ack_s;
    nxt_first_s  = first_s;
    nxt_cnt_s    = cnt_s;
    nxt_start    = 1'b0;
    nxt_stop     = 1'b0;
    nxt_err      = 1'b0;
    nxt_byte_val = val_s;
    nxt_obyte    = val_s ? byte_s  : obyte;
    nxt_oack     = val_s ? ack_s   : oack;
    nxt_ofirst   = val_s ? first_s : ofirst;
    nxt_ocnt     = val_s ? cnt_s   : ocnt;

    if (start_c) begin
      nxt_state    = ST_ADDR;
      nxt_bit_cnt  = '0;
      nxt_shreg    = '0;
      nxt_tcnt     = '0;
      nxt_byte_cnt = '0;
      nxt_ocnt     = '0;
      nxt_start    = 1'b1;
    end else if (stop_c && (state != ST_IDLE)) begin
      nxt_state   = ST_IDLE;
      nxt_bit_cnt = '0;
      nxt_shreg   = '0;
      nxt_tcnt    = '0;
      nxt_stop    = 1'b1;
    end else if (state != ST_IDLE) begin
      if (scl_edge_c) begin
        nxt_tcnt = '0;
        if (scl_rise_c) begin
          if (bit_cnt == ACK_BIT) begin
            nxt_bit_cnt  = '0;
            nxt_byte_cnt = (byte_cnt == CNT_MAX) ? CNT_MAX : byte_cnt + BYTE_W'(1);
            nxt_val_s    = 1'b1;
            nxt_byte_s   = shreg;
            nxt_ack_s    = ~sda_l;
            nxt_first_s  = (state == ST_ADDR);
            nxt_cnt_s    = nxt_byte_cnt;
            nxt_state    = ST_DATA;
          end else begin
            nxt_shreg   = {shreg[6:0], sda_l};
            nxt_bit_cnt = bit_cnt + BIT_W'(1);
          end
        end
      end else if (tcnt == TOUT_LAST) begin
        nxt_state   = ST_IDLE;
        nxt_bit_cnt = '0;
        nxt_shreg   = '0;
        nxt_tcnt    = '0;
        nxt_err     = 1'b1;
      end else begin
        nxt_tcnt = tcnt + TOUT_W'(1);
      end
    end

    nxt_busy = (nxt_state != ST_IDLE);
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Testbench for i2c_bus_monitor: bus-level stimulus, event scoreboard and monitor.
module tb_i2c_bus_monitor;

  localparam int unsigned FILT_LEN = 4;
  localparam int unsigned TOUT     = 768;

  localparam int K_START = 0;
  localparam int K_STOP  = 1;
  localparam int K_ERR   = 2;
  localparam int K_BYTE  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda;
  logic       obusy, ostart, ostop, oerr, obyte_val, oack, ofirst;
  logic [7:0] obyte, ocnt;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         kind;
    int         at;
    logic [7:0] b;
    logic       ack;
    logic       first;
    logic [7:0] cnt;
  } ev_t;

  ev_t exp_q[$];

  // Bus model state: busy flag and bytes since START.
  bit m_busy = 1'b0;
  int m_cnt  = 0;
  int q      = 4;
  int h      = 8;
  int last_fall = 0;

  i2c_bus_monitor #(.FILT_LEN(FILT_LEN), .TOUT(TOUT)) dut (
    .iclk     (clk),
    .irst     (rst),
    .isck     (scl),
    .isda     (sda),
    .obusy    (obusy),
    .ostart   (ostart),
    .ostop    (ostop),
    .oerr     (oerr),
    .obyte_val(obyte_val),
    .obyte    (obyte),
    .oack     (oack),
    .ofirst   (ofirst),
    .ocnt     (ocnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void push(input int kind, input int at, input logic [7:0] b,
                               input logic ack, input logic first, input logic [7:0] cnt);
    ev_t e;
    e.kind = kind; e.at = at; e.b = b; e.ack = ack; e.first = first; e.cnt = cnt;
    exp_q.push_back(e);
  endfunction

  // Bus-level actions; each pushes the events the protocol says must follow.
  task automatic i2c_start();
    if (scl == 1'b0) begin
      sda = 1'b1; waitc(q);
      scl = 1'b1; waitc(q);
    end
    push(K_START, cyc + int'(FILT_LEN) + 4, 8'h00, 1'b0, 1'b0, 8'h00);
    m_busy = 1'b1;
    m_cnt  = 0;
    sda = 1'b0; waitc(q);
    scl = 1'b0; last_fall = cyc; waitc(q);
  endtask

  task automatic send_bit(input logic b);
    sda = b; waitc(q);
    scl = 1'b1; waitc(h);
    scl = 1'b0; last_fall = cyc; waitc(q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic nack);
    m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    push(K_BYTE, 0, b, ~nack, (m_cnt == 1), 8'(m_cnt));
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda = nack; waitc(q);
    exp_q[exp_q.size()-1].at = cyc + int'(FILT_LEN) + 5;
    scl = 1'b1; waitc(h);
    scl = 1'b0; last_fall = cyc; waitc(q);
  endtask

  task automatic i2c_stop();
    sda = 1'b0; waitc(q);
    scl = 1'b1; waitc(q);
    if (m_busy) push(K_STOP, cyc + int'(FILT_LEN) + 4, 8'h00, 1'b0, 1'b0, 8'h00);
    m_busy = 1'b0;
    sda = 1'b1; waitc(q);
  endtask

  // Pops one expected event per observed DUT event and compares it.
  task automatic monitor_loop();
    ev_t e;
    int  nk;
    int  kind;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nk = int'(ostart) + int'(ostop) + int'(oerr) + int'(obyte_val);
        if (nk > 0) begin
          kind = ostart ? K_START : ostop ? K_STOP : oerr ? K_ERR : K_BYTE;
          if (nk > 1) chk("single_event", nk, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_latency", cyc, e.at);
            if (kind == K_BYTE) begin
              chk("obyte", obyte, e.b);
              chk("oack", oack, e.ack);
              chk("ofirst", ofirst, e.first);
              chk("ocnt", ocnt, e.cnt);
            end else if (kind == K_START) begin
              chk("busy_on_start", obusy, 1);
              chk("ocnt_cleared", ocnt, 0);
            end else begin
              chk("busy_off", obusy, 0);
            end
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset on an idle bus.
    rst = 1'b1; scl = 1'b1; sda = 1'b1;
    waitc(4);
    chk("reset_outputs", {obusy, ostart, ostop, oerr, obyte_val, obyte, oack, ofirst, ocnt}, 0);
    rst = 1'b0;
    waitc(30);
    chk("idle_after_reset", obusy, 0);

    // Write at 400 kHz: A0 ACK, 5A ACK.
    q = 60; h = 120;
    i2c_start();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h5A, 1'b0);
    i2c_stop();
    waitc(20);
    chk("idle_after_write", obusy, 0);

    // Read with NACK on the data byte.
    q = 6; h = 12;
    i2c_start();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hFF, 1'b1);
    i2c_stop();
    waitc(20);

    // Repeated START after 4 data bits.
    i2c_start();
    send_byte(8'hA0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i));
    i2c_start();
    send_byte(8'h3C, 1'b0);
    i2c_stop();
    waitc(20);

    // Glitch rejection: 3-cycle SDA low with SCL high, then 5-cycle low.
    sda = 1'b0; waitc(3);
    sda = 1'b1; waitc(30);
    chk("glitch_busy", obusy, 0);
    push(K_START, cyc + int'(FILT_LEN) + 4, 8'h00, 1'b0, 1'b0, 8'h00);
    sda = 1'b0; waitc(5);
    push(K_STOP, cyc + int'(FILT_LEN) + 4, 8'h00, 1'b0, 1'b0, 8'h00);
    sda = 1'b1; waitc(30);
    chk("pulse_busy", obusy, 0);

    // Timeout: 3 address bits then SCL held low.
    i2c_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    push(K_ERR, last_fall + int'(TOUT) + int'(FILT_LEN) + 4, 8'h00, 1'b0, 1'b0, 8'h00);
    m_busy = 1'b0;
    waitc(800);
    chk("timeout_busy", obusy, 0);
    scl = 1'b1; waitc(q);
    sda = 1'b1; waitc(30);

    // STOP pattern while idle is ignored.
    scl = 1'b0; waitc(q);
    i2c_stop();
    waitc(30);

    // Reset during the 6th data bit, with SCL low.
    i2c_start();
    send_byte(8'h50, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    sda = 1'b0; waitc(2);
    rst = 1'b1; waitc(1);
    rst = 1'b0;
    m_busy = 1'b0;
    chk("midframe_reset_outputs", {obusy, ostart, ostop, oerr, obyte_val, obyte, oack, ofirst, ocnt}, 0);
    waitc(40);
    chk("midframe_reset_busy", obusy, 0);
    sda = 1'b1; waitc(q);
    scl = 1'b1; waitc(30);
    i2c_start();
    send_byte(8'h78, 1'b0);
    send_byte(8'h96, 1'b1);
    i2c_stop();
    waitc(20);

    // Randomised transactions with optional repeated START after a partial byte.
    for (int t = 0; t < 6; t++) begin
      q = int'($urandom_range(4, 12));
      h = int'($urandom_range(8, 24));
      i2c_start();
      for (int n = int'($urandom_range(1, 4)); n > 0; n--)
        send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = int'($urandom_range(0, 7)); k > 0; k--) send_bit(1'($urandom_range(0, 1)));
        i2c_start();
        send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
      i2c_stop();
      waitc(20);
    end

    // Byte counter saturation at 255.
    q = 4; h = 8;
    i2c_start();
    for (int n = 0; n < 257; n++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    i2c_stop();

    // Drain the scoreboard within a bounded time.
    for (int w = 0; w < 2000 && exp_q.size() != 0; w++) waitc(1);
    waitc(20);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_idle", obusy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
